// File: rtl/ad9434_idelay_cal.sv
// ---------------------------------------------------------------------------
// ad9434_idelay_cal
//
// Per-lane IDELAYE2 tap calibration for the AD9434 LVDS DDR capture path.
// While the ADC drives a known test pattern, every tap (0..2**TAP_W-1) is
// loaded on all lanes at once, allowed to settle, and then scored over
// CHECK_CYCLES consecutive Q1/Q2 samples. Each lane tracks its widest run of
// passing taps. At the end of the sweep the centre of that run is loaded
// into the IDELAY, or DEFAULT_TAP if the run is narrower than MIN_EYE.
//
// Ports
//   adc_clk_i            capture clock, also drives the IDELAYE2 C pin
//   rst_i                synchronous active-high reset
//   cal_start_i          one-cycle start pulse (honoured in IDLE/DONE only)
//   idelay_rdy_i         IDELAYCTRL RDY; a drop mid-sweep restarts the sweep
//   data_q1_i/data_q2_i  registered IDDR Q1/Q2 bit per lane
//   exp_q1_i/exp_q2_i    expected Q1/Q2 bit per lane (static while busy)
//   idelay_ld_o          per-lane IDELAYE2 LD
//   idelay_cntvaluein_o  per-lane CNTVALUEIN, lane i at [i*TAP_W +: TAP_W]
//   cal_busy_o           sweep in progress
//   cal_done_o           sticky completion flag, cleared by cal_start_i
//   cal_fail_o           lane found no window of at least MIN_EYE taps
//   lane_tap_o           final tap per lane
//   lane_eye_o           widest passing window per lane (0..2**TAP_W)
// ---------------------------------------------------------------------------
module ad9434_idelay_cal #(
    parameter int NUM_LANES     = 6,
    parameter int TAP_W         = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int CHECK_CYCLES  = 256,
    parameter int MIN_EYE       = 4,
    parameter int DEFAULT_TAP   = 19
) (
    input  logic                           adc_clk_i,
    input  logic                           rst_i,
    input  logic                           cal_start_i,
    input  logic                           idelay_rdy_i,
    input  logic [NUM_LANES-1:0]           data_q1_i,
    input  logic [NUM_LANES-1:0]           data_q2_i,
    input  logic [NUM_LANES-1:0]           exp_q1_i,
    input  logic [NUM_LANES-1:0]           exp_q2_i,
    output logic [NUM_LANES-1:0]           idelay_ld_o,
    output logic [NUM_LANES*TAP_W-1:0]     idelay_cntvaluein_o,
    output logic                           cal_busy_o,
    output logic                           cal_done_o,
    output logic [NUM_LANES-1:0]           cal_fail_o,
    output logic [NUM_LANES*TAP_W-1:0]     lane_tap_o,
    output logic [NUM_LANES*(TAP_W+1)-1:0] lane_eye_o
);

    localparam int LEN_W   = TAP_W + 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TAP_W-1:0] TAP_LAST    = '1;
    localparam logic [TAP_W-1:0] TAP_ONE     = TAP_W'(1);
    localparam logic [TAP_W-1:0] DEF_TAP     = TAP_W'(DEFAULT_TAP);
    localparam logic [LEN_W-1:0] LEN_ZERO    = '0;
    localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] MIN_EYE_L   = LEN_W'(MIN_EYE);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_SCORE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t                         state_q;
    logic [TAP_W-1:0]               tap_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [NUM_LANES-1:0]           pass_q;

    // Per-lane window trackers; cleared on every (re)start of the sweep,
    // so they need no reset of their own.
    logic [LEN_W-1:0]               run_len_q    [NUM_LANES];
    logic [TAP_W-1:0]               run_start_q  [NUM_LANES];
    logic [LEN_W-1:0]               best_len_q   [NUM_LANES];
    logic [TAP_W-1:0]               best_start_q [NUM_LANES];

    logic [NUM_LANES-1:0]           ld_q;
    logic [NUM_LANES*TAP_W-1:0]     cntval_q;
    logic                           busy_q;
    logic                           done_q;
    logic [NUM_LANES-1:0]           fail_q;
    logic [NUM_LANES*TAP_W-1:0]     lane_tap_q;
    logic [NUM_LANES*LEN_W-1:0]     lane_eye_q;

    // Tracker values after scoring the current tap, and the centre tap
    // derived from them. The final tap is computed from these so that the
    // APPLY cycle already presents the final LD/CNTVALUEIN.
    logic [LEN_W-1:0]               run_len_d    [NUM_LANES];
    logic [TAP_W-1:0]               run_start_d  [NUM_LANES];
    logic [LEN_W-1:0]               best_len_d   [NUM_LANES];
    logic [TAP_W-1:0]               best_start_d [NUM_LANES];
    logic [TAP_W-1:0]               final_tap_d  [NUM_LANES];
    logic [NUM_LANES-1:0]           fail_d;

    logic [NUM_LANES-1:0]           lane_ok;
    logic [TAP_W-1:0]               tap_nxt;

    assign lane_ok = ~((data_q1_i ^ exp_q1_i) | (data_q2_i ^ exp_q2_i));
    assign tap_nxt = tap_q + TAP_ONE;

    always_comb begin
        fail_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            run_len_d[i]    = LEN_ZERO;
            run_start_d[i]  = run_start_q[i];
            if (pass_q[i]) begin
                run_len_d[i]   = run_len_q[i] + LEN_ONE;
                run_start_d[i] = (run_len_q[i] == LEN_ZERO) ? tap_q : run_start_q[i];
            end

            // Strictly greater: on a tie the earlier window is kept.
            best_len_d[i]   = best_len_q[i];
            best_start_d[i] = best_start_q[i];
            if (run_len_d[i] > best_len_q[i]) begin
                best_len_d[i]   = run_len_d[i];
                best_start_d[i] = run_start_d[i];
            end

            // The window lies inside 0..TAP_LAST, so start + len/2 cannot
            // overflow TAP_W bits.
            if (best_len_d[i] >= MIN_EYE_L) begin
                final_tap_d[i] = best_start_d[i] + TAP_W'(best_len_d[i] >> 1);
                fail_d[i]      = 1'b0;
            end else begin
                final_tap_d[i] = DEF_TAP;
                fail_d[i]      = 1'b1;
            end
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            tap_q      <= '0;
            cnt_q      <= '0;
            ld_q       <= '0;
            cntval_q   <= {NUM_LANES{DEF_TAP}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= '0;
            lane_tap_q <= {NUM_LANES{DEF_TAP}};
            lane_eye_q <= '0;
        end else begin
            // LD is a single-cycle strobe; only the LOAD and APPLY entries raise it.
            ld_q <= '0;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cal_start_i) begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_WAIT_RDY;
                    end
                end

                S_WAIT_RDY: begin
                    if (idelay_rdy_i) begin
                        tap_q    <= '0;
                        pass_q   <= '0;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            run_len_q[i]    <= LEN_ZERO;
                            run_start_q[i]  <= '0;
                            best_len_q[i]   <= LEN_ZERO;
                            best_start_q[i] <= '0;
                        end
                        cntval_q <= '0;
                        ld_q     <= '1;
                        state_q  <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    cnt_q <= '0;
                    if (!idelay_rdy_i) begin
                        state_q <= S_WAIT_RDY;
                    end else begin
                        state_q <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (!idelay_rdy_i) begin
                        state_q <= S_WAIT_RDY;
                    end else if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        pass_q  <= '1;
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_CHECK: begin
                    if (!idelay_rdy_i) begin
                        state_q <= S_WAIT_RDY;
                    end else begin
                        pass_q <= pass_q & lane_ok;
                        if (cnt_q == CHECK_LAST) begin
                            state_q <= S_SCORE;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end

                S_SCORE: begin
                    if (!idelay_rdy_i) begin
                        state_q <= S_WAIT_RDY;
                    end else begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            run_len_q[i]    <= run_len_d[i];
                            run_start_q[i]  <= run_start_d[i];
                            best_len_q[i]   <= best_len_d[i];
                            best_start_q[i] <= best_start_d[i];
                        end
                        if (tap_q == TAP_LAST) begin
                            // Final results go out registered so that they
                            // are on the pins during the APPLY cycle.
                            for (int i = 0; i < NUM_LANES; i++) begin
                                cntval_q[i*TAP_W +: TAP_W]   <= final_tap_d[i];
                                lane_tap_q[i*TAP_W +: TAP_W] <= final_tap_d[i];
                                lane_eye_q[i*LEN_W +: LEN_W] <= best_len_d[i];
                            end
                            fail_q  <= fail_d;
                            ld_q    <= '1;
                            state_q <= S_APPLY;
                        end else begin
                            tap_q    <= tap_nxt;
                            cntval_q <= {NUM_LANES{tap_nxt}};
                            ld_q     <= '1;
                            state_q  <= S_LOAD;
                        end
                    end
                end

                S_APPLY: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign idelay_ld_o         = ld_q;
    assign idelay_cntvaluein_o = cntval_q;
    assign cal_busy_o          = busy_q;
    assign cal_done_o          = done_q;
    assign cal_fail_o          = fail_q;
    assign lane_tap_o          = lane_tap_q;
    assign lane_eye_o          = lane_eye_q;

endmodule

// File: tb/tb_ad9434_idelay_cal.sv
// ---------------------------------------------------------------------------
// tb_ad9434_idelay_cal
//
// Models an IDELAY per lane (tap latched on LD) feeding a data source that
// returns the expected pattern only for taps inside that lane's pass mask.
// Sweep scenarios come from a table; expected results are queued when a
// sweep is started and compared when cal_done rises.
// ---------------------------------------------------------------------------
module tb_ad9434_idelay_cal;

    localparam int N  = 6;
    localparam int TW = 5;
    localparam int LW = 6;
    localparam int PERIOD_CYC = 274;
    localparam int DONE_LAT   = 32 * PERIOD_CYC + 3;

    typedef struct packed {
        logic [N-1:0][31:0]   win;
        logic                 corrupt;
        logic [N-1:0][TW-1:0] tap;
        logic [N-1:0][LW-1:0] eye;
        logic [N-1:0]         fail;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            rdy;
    logic [N-1:0]    data_q1;
    logic [N-1:0]    data_q2;
    logic [N-1:0]    exp_q1;
    logic [N-1:0]    exp_q2;
    logic [N-1:0]    ld;
    logic [N*TW-1:0] cntval;
    logic            busy;
    logic            done;
    logic [N-1:0]    fail;
    logic [N*TW-1:0] lane_tap;
    logic [N*LW-1:0] lane_eye;

    int n_pass  = 0;
    int n_total = 0;

    logic [N-1:0][31:0] win_cur;
    logic               corrupt_cur;
    int                 ld_total;
    int                 ld_base;

    vec_t tbl [3];
    vec_t sb_q [$];

    always #5 clk = ~clk;

    ad9434_idelay_cal dut (
        .adc_clk_i           (clk),
        .rst_i               (rst),
        .cal_start_i         (start),
        .idelay_rdy_i        (rdy),
        .data_q1_i           (data_q1),
        .data_q2_i           (data_q2),
        .exp_q1_i            (exp_q1),
        .exp_q2_i            (exp_q2),
        .idelay_ld_o         (ld),
        .idelay_cntvaluein_o (cntval),
        .cal_busy_o          (busy),
        .cal_done_o          (done),
        .cal_fail_o          (fail),
        .lane_tap_o          (lane_tap),
        .lane_eye_o          (lane_eye)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int b = lo; b <= hi; b++) m[b] = 1'b1;
        return m;
    endfunction

    // IDELAY + ADC model, LD pulse monitor.
    initial begin
        logic                 ld_prev;
        int                   k;
        logic                 arm;
        logic [N-1:0][TW-1:0] model_tap;
        ld_prev   = 1'b0;
        k         = 1000;
        arm       = 1'b0;
        ld_total  = 0;
        model_tap = '0;
        data_q1   = '0;
        data_q2   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ld_prev) check("ld_one_cycle", ld, 0);
            if (ld != '0) begin
                check("ld_all_lanes", ld, {N{1'b1}});
                if (ld_total - ld_base < 32)
                    check("ld_tap", cntval, {N{5'(ld_total - ld_base)}});
                model_tap = cntval;
                arm       = (model_tap[1] == 5'd12);
                k         = 0;
                ld_total++;
            end else if (k < 1000) begin
                k++;
            end
            ld_prev = |ld;
            for (int l = 0; l < N; l++) begin
                data_q1[l] = win_cur[l][model_tap[l]] ? exp_q1[l] : ~exp_q1[l];
                data_q2[l] = win_cur[l][model_tap[l]] ? exp_q2[l] : ~exp_q2[l];
            end
            // CHECK cycle 100 of the tap-12 period on lane 1.
            if (corrupt_cur && arm && k == 17 + 100) data_q2[1] = ~data_q2[1];
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ld"}, ld, 0);
        check({tag, "_cntval"}, cntval, {N{5'd19}});
        check({tag, "_lane_tap"}, lane_tap, {N{5'd19}});
        check({tag, "_lane_eye"}, lane_eye, 0);
        check({tag, "_fail"}, fail, 0);
    endtask

    task automatic start_sweep(input vec_t v);
        win_cur     = v.win;
        corrupt_cur = v.corrupt;
        ld_base     = ld_total;
        sb_q.push_back(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
    endtask

    task automatic wait_done(input int poke_at, output int cycles);
        cycles = 1;
        while (!done && cycles < 9500) begin
            start = (poke_at >= 0 && cycles == poke_at);
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        check("done_timeout", done, 1);
    endtask

    task automatic wait_loads(input int n);
        int c;
        c = 0;
        while (ld_total - ld_base < n && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("loads_reached", (ld_total - ld_base >= n), 1);
    endtask

    task automatic check_result();
        vec_t v;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        v = sb_q.pop_front();
        for (int l = 0; l < N; l++) begin
            check($sformatf("lane%0d_tap", l), lane_tap[l*TW +: TW], v.tap[l]);
            check($sformatf("lane%0d_eye", l), lane_eye[l*LW +: LW], v.eye[l]);
        end
        check("cal_fail", fail, v.fail);
        check("cntval_final", cntval, v.tap);
        check("busy_done", busy, 0);
        check("ld_count", ld_total - ld_base, 33);
    endtask

    initial begin
        int cyc;
        rst         = 1'b1;
        start       = 1'b0;
        rdy         = 1'b1;
        exp_q1      = 6'b101010;
        exp_q2      = 6'b010011;
        win_cur     = '0;
        corrupt_cur = 1'b0;
        ld_base     = 0;

        // Lane 0 8..20, others 10..13.
        tbl[0] = '0;
        for (int l = 0; l < N; l++) begin
            tbl[0].win[l] = (l == 0) ? rng(8, 20) : rng(10, 13);
            tbl[0].tap[l] = (l == 0) ? 5'd14 : 5'd12;
            tbl[0].eye[l] = (l == 0) ? 6'd13 : 6'd4;
        end
        tbl[0].fail = '0;

        // Window at tap 31, split windows, tie, too-narrow, mid-check glitch.
        tbl[1] = '0;
        tbl[1].win[0] = rng(8, 20);            tbl[1].tap[0] = 5'd14; tbl[1].eye[0] = 6'd13;
        tbl[1].win[1] = rng(8, 20);            tbl[1].tap[1] = 5'd17; tbl[1].eye[1] = 6'd8;
        tbl[1].win[2] = rng(26, 31);           tbl[1].tap[2] = 5'd29; tbl[1].eye[2] = 6'd6;
        tbl[1].win[3] = rng(2, 5) | rng(10, 20); tbl[1].tap[3] = 5'd15; tbl[1].eye[3] = 6'd11;
        tbl[1].win[4] = rng(3, 7) | rng(20, 24); tbl[1].tap[4] = 5'd5;  tbl[1].eye[4] = 6'd5;
        tbl[1].win[5] = rng(0, 2);             tbl[1].tap[5] = 5'd19; tbl[1].eye[5] = 6'd3;
        tbl[1].corrupt = 1'b1;
        tbl[1].fail    = 6'b100000;

        // Full eye, exactly MIN_EYE, empty, single tap 31, alternating, 28..31.
        tbl[2] = '0;
        tbl[2].win[0] = rng(0, 31);    tbl[2].tap[0] = 5'd16; tbl[2].eye[0] = 6'd32;
        tbl[2].win[1] = rng(0, 3);     tbl[2].tap[1] = 5'd2;  tbl[2].eye[1] = 6'd4;
        tbl[2].win[2] = '0;            tbl[2].tap[2] = 5'd19; tbl[2].eye[2] = 6'd0;
        tbl[2].win[3] = rng(31, 31);   tbl[2].tap[3] = 5'd19; tbl[2].eye[3] = 6'd1;
        tbl[2].win[4] = 32'h5555_5555; tbl[2].tap[4] = 5'd19; tbl[2].eye[4] = 6'd1;
        tbl[2].win[5] = rng(28, 31);   tbl[2].tap[5] = 5'd30; tbl[2].eye[5] = 6'd4;
        tbl[2].fail = 6'b011100;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Table sweeps; the first one also gets a cal_start during CHECK of tap 2.
        for (int i = 0; i < 3; i++) begin
            start_sweep(tbl[i]);
            wait_done((i == 0) ? (2 + 2 * PERIOD_CYC + 100) : -1, cyc);
            check("done_latency", cyc, DONE_LAT);
            check_result();
        end

        // Reset in the middle of tap 9.
        start_sweep(tbl[0]);
        wait_loads(10);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("rst_tap9");
        void'(sb_q.pop_back());
        ld_base = ld_total;
        repeat (20) @(posedge clk);
        #1;
        check("idle_no_ld", ld_total - ld_base, 0);
        check("idle_busy", busy, 0);
        start_sweep(tbl[0]);
        wait_done(-1, cyc);
        check("done_latency_after_rst", cyc, DONE_LAT);
        check_result();

        // RDY low after start, then a RDY drop at tap 5.
        rdy = 1'b0;
        start_sweep(tbl[1]);
        repeat (50) @(posedge clk);
        #1;
        check("no_load_without_rdy", ld_total - ld_base, 0);
        check("busy_waiting_rdy", busy, 1);
        rdy = 1'b1;
        wait_loads(6);
        repeat (40) @(posedge clk);
        #1;
        rdy     = 1'b0;
        ld_base = ld_total;
        repeat (5) @(posedge clk);
        #1;
        check("no_load_while_aborted", ld_total - ld_base, 0);
        rdy = 1'b1;
        wait_done(-1, cyc);
        check_result();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
